seg7_scan_driver: RTL

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit debug display driver. It scans DIGITS common-anode digits from a hex data bus. Adds frame-coherent input capture, a freeze (hold) control, per-digit decimal points, leading-zero blanking and a global blink mode. It sits between the CPU debug mux (pc, clock_count, test_out selection) and the board anode/segment pins.

---
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the debug mux and the scan driver: hex data, per-digit
// decimal points and display controls in, anode/segment pin drive out.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic                hold;
  logic                blink_en;
  logic [DIGITS-1:0]   anode;
  logic [7:0]          segment;

  // The source of the display value (CPU debug mux or a bench).
  modport master (
    output data, dp, blank_lz, hold, blink_en,
    input  anode, segment
  );

  // The scan driver itself.
  modport slave (
    input  data, dp, blank_lz, hold, blink_en,
    output anode, segment
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver. Scans DIGITS digits, one slot
// of 2^DIV_BITS clocks each. The shown value is sampled once per frame when the
// scan wraps to digit 0, so a frame never mixes two data samples. Supports
// freeze, per-digit decimal points, leading-zero blanking and global blink.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int DIV_BITS   = 16,
  parameter int BLINK_BITS = 6
) (
  input logic               clock,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0]   prescaler;
  logic [IDX_W-1:0]      digit_idx;
  logic [IDX_W-1:0]      idx_next;
  logic [BLINK_BITS-1:0] frame_cnt;
  logic [BLINK_BITS-1:0] frame_cnt_next;
  logic [4*DIGITS-1:0]   frame_data;
  logic [4*DIGITS-1:0]   frame_data_next;
  logic [DIGITS-1:0]     frame_dp;
  logic [DIGITS-1:0]     frame_dp_next;
  logic [DIGITS-1:0]     anode_q;
  logic [DIGITS-1:0]     anode_d;
  logic [7:0]            segment_q;
  logic [7:0]            segment_d;
  logic                  tick;
  logic                  wrap;
  logic                  capture;
  logic                  zero_above;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            nibble;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Slot timing, frame capture and the pin pattern for the digit that becomes
  // active on this tick. At a wrap the freshly captured frame is used, so digit
  // 0 already shows the new sample and the whole frame comes from one capture.
  always_comb begin
    tick            = &prescaler;
    wrap            = tick && (digit_idx == LAST_IDX);
    idx_next        = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    capture         = wrap && !bus.hold;
    frame_cnt_next  = wrap ? frame_cnt + 1'b1 : frame_cnt;
    frame_data_next = capture ? bus.data : frame_data;
    frame_dp_next   = capture ? bus.dp : frame_dp;

    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (frame_data_next[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above && (i > 0);
    end

    nibble  = frame_data_next[4*idx_next +: 4];
    anode_d = ~(DIGITS'(1) << idx_next);
    if (bus.blank_lz && lz_mask[idx_next]) begin
      segment_d = {~frame_dp_next[idx_next], 7'h7F};
    end else begin
      segment_d = {~frame_dp_next[idx_next], hex_to_seg(nibble)};
    end

    if (bus.blink_en && frame_cnt_next[BLINK_BITS-1]) begin
      anode_d   = '1;
      segment_d = 8'hFF;
    end
  end

  // Free-running prescaler; the slot tick is its all-ones state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Scan position, frame counter and the captured frame advance on ticks only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_idx  <= '0;
      frame_cnt  <= '0;
      frame_data <= '0;
      frame_dp   <= '0;
    end else if (tick) begin
      digit_idx  <= idx_next;
      frame_cnt  <= frame_cnt_next;
      frame_data <= frame_data_next;
      frame_dp   <= frame_dp_next;
    end
  end

  // Anode and segment are registered together so they never skew.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_q   <= '1;
      segment_q <= 8'hFF;
    end else if (tick) begin
      anode_q   <= anode_d;
      segment_q <= segment_d;
    end
  end

  assign bus.anode   = anode_q;
  assign bus.segment = segment_q;

endmodule
